// File: rtl/rr_arb8_32bits_pkg.sv
// Shared constants and helpers for the 8-input round-robin result-bus arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: requester count, index width, default last-winner pointer,
// reset fill bit for the output word, and a rotate helper used by the picker.
package rr_arb8_32bits_pkg;

  localparam int NREQ = 8;
  localparam int IDXW = 3;

  // 7 so that requester 0 is scanned first after reset.
  localparam logic [IDXW-1:0] PTR_INIT_DEF = 3'd7;

  // Every bit of y takes this value on reset.
  localparam logic Y_RST_BIT = 1'b0;

  // Rotate right by n: bit n of v lands on bit 0.
  function automatic logic [NREQ-1:0] rot_right8(input logic [NREQ-1:0] v,
                                                 input logic [IDXW-1:0] n);
    logic [2*NREQ-1:0] d;
    d = {v, v} >> n;
    return d[NREQ-1:0];
  endfunction

endpackage

// File: rtl/rr_pick8.sv
// Round-robin picker: first set request strictly after ptr, wrapping 7 -> 0.
// Latency: purely combinational.
// Backpressure: none; caller decides whether the pick is used.
//
// Ports: req_i[7:0] requests, ptr_i[2:0] last winner;
//        any_o some request set, idx_o winner index, onehot_o decoded winner
//        (all zero when no request is set).
module rr_pick8
  import rr_arb8_32bits_pkg::*;
(
  input  logic [NREQ-1:0] req_i,
  input  logic [IDXW-1:0] ptr_i,
  output logic            any_o,
  output logic [IDXW-1:0] idx_o,
  output logic [NREQ-1:0] onehot_o
);

  logic [IDXW-1:0] start;
  logic [NREQ-1:0] rot;
  logic [IDXW-1:0] off;

  // Scanning begins one past the last winner; 3-bit add wraps 7 -> 0.
  assign start = ptr_i + 3'd1;
  assign rot   = rot_right8(req_i, start);

  // Priority-encode the rotated vector: lowest set bit wins, so walk downward
  // and let the last hit overwrite.
  always_comb begin
    off = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (rot[i]) off = IDXW'(i);
    end
  end

  // Un-rotate back to a requester index.
  assign idx_o    = start + off;
  assign any_o    = |req_i;
  assign onehot_o = any_o ? ({{(NREQ-1){1'b0}}, 1'b1} << idx_o) : '0;

endmodule

// File: rtl/rr_arb8_32bits.sv
// Round-robin arbiter for 8 requesters sharing one 32-bit registered result bus.
// Latency: request seen with buffer free -> word valid on y_o one cycle later.
// Backpressure: one-entry buffer; while y_valid_o=1 and y_ready_i=0 no grant is issued.
//
// Ports: clk_i, reset_i (sync, active-high); req_i[7:0] and a_i..h_i data of
//        requesters 0..7; grant_o one-hot capture acknowledge; sel_o index of
//        last captured requester; y_valid_o/y_o/y_ready_i output handshake;
//        ptr_o last-winner pointer for visibility.
module rr_arb8_32bits
  import rr_arb8_32bits_pkg::*;
#(
  parameter int              WIDTH    = 32,
  parameter logic [IDXW-1:0] PTR_INIT = PTR_INIT_DEF
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic [NREQ-1:0]  req_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [WIDTH-1:0] c_i,
  input  logic [WIDTH-1:0] d_i,
  input  logic [WIDTH-1:0] e_i,
  input  logic [WIDTH-1:0] f_i,
  input  logic [WIDTH-1:0] g_i,
  input  logic [WIDTH-1:0] h_i,
  output logic [NREQ-1:0]  grant_o,
  output logic [IDXW-1:0]  sel_o,
  output logic             y_valid_o,
  output logic [WIDTH-1:0] y_o,
  input  logic             y_ready_i,
  output logic [IDXW-1:0]  ptr_o
);

  logic [WIDTH-1:0] y_q, y_d;
  logic             y_valid_q, y_valid_d;
  logic [IDXW-1:0]  sel_q, sel_d;
  logic [IDXW-1:0]  ptr_q, ptr_d;

  logic             pick_any;
  logic [IDXW-1:0]  pick_idx;
  logic [NREQ-1:0]  pick_onehot;
  logic             free;
  logic             cap;
  logic [WIDTH-1:0] mux_dat;

  rr_pick8 u_pick (
    .req_i    (req_i),
    .ptr_i    (ptr_q),
    .any_o    (pick_any),
    .idx_o    (pick_idx),
    .onehot_o (pick_onehot)
  );

  // Buffer can take a word if empty or being drained this cycle.
  assign free = !y_valid_q || y_ready_i;
  assign cap  = free && pick_any && !reset_i;

  assign grant_o = cap ? pick_onehot : '0;

  // Mux is steered by the live winner, not the registered sel, so the
  // captured word always belongs to the granted requester.
  always_comb begin
    mux_dat = h_i;
    case (pick_idx)
      3'd0:    mux_dat = a_i;
      3'd1:    mux_dat = b_i;
      3'd2:    mux_dat = c_i;
      3'd3:    mux_dat = d_i;
      3'd4:    mux_dat = e_i;
      3'd5:    mux_dat = f_i;
      3'd6:    mux_dat = g_i;
      default: mux_dat = h_i;
    endcase
  end

  always_comb begin
    y_d       = y_q;
    y_valid_d = y_valid_q;
    sel_d     = sel_q;
    ptr_d     = ptr_q;
    if (cap) begin
      y_d       = mux_dat;
      y_valid_d = 1'b1;
      sel_d     = pick_idx;
      ptr_d     = pick_idx;
    end else if (y_ready_i) begin
      // Consumed (or already empty) with nothing new arriving.
      y_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      y_q       <= {WIDTH{Y_RST_BIT}};
      y_valid_q <= 1'b0;
      sel_q     <= '0;
      ptr_q     <= PTR_INIT;
    end else begin
      y_q       <= y_d;
      y_valid_q <= y_valid_d;
      sel_q     <= sel_d;
      ptr_q     <= ptr_d;
    end
  end

  assign y_o       = y_q;
  assign y_valid_o = y_valid_q;
  assign sel_o     = sel_q;
  assign ptr_o     = ptr_q;

endmodule
